occupancy_tracker: RTL and testbench
====================================

// Module: occupancy_tracker
// PURPOSE
//  Consumes the raw `parked` flag from the PmodJSTK sensor stage, which is asynchronous to clk and bouncy.
//  Synchronises and debounces it, then runs the bay-occupancy FSM.
//  Emits single-cycle arrive/depart events and a seconds-resolution dwell time for the meter/billing logic downstream.
// PARAMETERS
//  DEBOUNCE_CYCLES  5_000_000    consecutive clk cycles a new level must hold before it is accepted (50 ms @100 MHz)
//  TICK_DIV         100_000_000  clk cycles per dwell second
//  DUR_W            16           width of dwell counters, in seconds; saturating
//  GRACE_SEC        3            departure grace period in seconds; used only with OCC_GRACE_EN
// PORTS
//  clk             in   1      system clock, 100 MHz
//  rst_n           in   1      synchronous, active-low reset
//  parked_raw      in   1      raw occupancy flag from the sensor stage; asynchronous
//  occupied        out  1      1 while the bay is held (OCCUPIED, or GRACE when enabled)
//  arrive_pulse    out  1      1-cycle pulse on vacant->occupied
//  depart_pulse    out  1      1-cycle pulse on transition to VACANT
//  dwell_sec       out  DUR_W  seconds elapsed in the current or most recent stay
//  last_dwell_sec  out  DUR_W  dwell_sec value captured at the most recent departure
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=VACANT; sync flops, debounced level, debounce count, prescaler and grace count all 0.
//   - All outputs 0.
//  Synchroniser: two flops, parked_raw -> parked_s.
//  Debounce:
//   - Tracks `stable`. When parked_s==stable, the count is cleared.
//   - Otherwise the count increments. When it reaches DEBOUNCE_CYCLES-1, stable<=parked_s and the count clears.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
//  Latency: a clean parked_raw edge produces the occupied/pulse edge exactly DEBOUNCE_CYCLES+3 clk edges after the first edge that samples the new level.
//  FSM:
//   - VACANT -> OCCUPIED on stable=1.
//     Same cycle: arrive_pulse=1, dwell_sec<=0, prescaler<=0.
//   - OCCUPIED -> VACANT on stable=0 (OCC_GRACE_EN undefined).
//     Same cycle: depart_pulse=1, last_dwell_sec<=dwell_sec.
//  Dwell timing:
//   - Prescaler runs 0..TICK_DIV-1 while occupied=1.
//   - On wrap, dwell_sec increments, saturating at 2^DUR_W-1 (no wrap-around).
//   - In VACANT, prescaler is held at 0 and dwell_sec is frozen at its last value.
//  Simultaneous events:
//   - Arrival and tick: the arrival wins; dwell_sec=0.
//   - Departure and tick: last_dwell_sec takes the pre-increment value and the tick is discarded.
//  Outputs are registered; arrive_pulse and depart_pulse are never both 1 in the same cycle.
//  Reset mid-stay: returns to VACANT with no depart_pulse; last_dwell_sec is cleared to 0.
// CONFIGURATION
//  Macro OCC_GRACE_EN:
//   - Defined: adds state GRACE.
//     - OCCUPIED -> GRACE on stable=0; occupied stays 1 and dwell keeps counting.
//     - GRACE -> OCCUPIED on stable=1; no pulses are emitted.
//     - Grace counter increments on each dwell tick. On reaching GRACE_SEC: GRACE -> VACANT with depart_pulse, and last_dwell_sec<=dwell_sec.
//     - Grace counter clears on every entry to GRACE.
//   - Undefined: no GRACE state; departure is immediate, as above.
// STRUCTURE
//  Shared header parking_defs.vh:
//   - FSM state encodings: VACANT=2'd0, OCCUPIED=2'd1, GRACE=2'd2.
//   - Default DEBOUNCE_CYCLES and TICK_DIV, shared with the other meter blocks.
//  Sub-module debounce_filter:
//   - Contents: synchroniser plus debounce counter.
//   - Parameter: DEBOUNCE_CYCLES.
//   - Ports: clk, rst_n, din, dout.
//   - Reusable for the meter push-buttons.
//  Top level holds the FSM, prescaler, dwell/last-dwell registers and grace counter.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, TICK_DIV=10, DUR_W=4, GRACE_SEC=2)
//  1. Reset release, parked_raw=0 for 50 cycles -> occupied=0, no pulses, dwell_sec=0, last_dwell_sec=0.
//  2. parked_raw 0->1 held -> arrive_pulse for exactly 1 cycle, 7 edges after the first sampling edge; occupied=1.
//     Then dwell_sec=1 after 10 more cycles and 3 after 30.
//  3. 3-cycle high glitch on parked_raw while VACANT -> no arrive_pulse, occupied stays 0.
//  4. Stay of 250 cycles -> dwell_sec saturates at 15 and does not wrap.
//     On departure: depart_pulse 1 cycle, last_dwell_sec=15, dwell_sec frozen at 15.
//  5. rst_n=0 for 1 cycle mid-stay -> next cycle occupied=0, dwell_sec=0, last_dwell_sec=0, no depart_pulse.
//  6. With OCC_GRACE_EN:
//     - Drop for 12 cycles, then return -> no pulses; occupied=1 throughout; dwell_sec keeps counting.
//     - Drop held -> depart_pulse 20 cycles after entering GRACE; last_dwell_sec includes the grace seconds.

Source files
------------

// File: rtl/occupancy_tracker_pkg.sv
// Shared definitions for the parking-meter blocks: bay FSM encodings and default timing constants.
package occupancy_tracker_pkg;

   typedef enum logic [1:0] {
      VACANT   = 2'd0,
      OCCUPIED = 2'd1,
      GRACE    = 2'd2
   } bay_state_e;

   // Defaults assume a 100 MHz clk: 50 ms debounce, 1 s dwell tick.
   localparam int DEF_DEBOUNCE_CYCLES = 5_000_000;
   localparam int DEF_TICK_DIV        = 100_000_000;

endpackage

// File: rtl/occupancy_tracker_debounce_filter.sv
// Two-flop synchroniser followed by a level debouncer; reusable for any slow, bouncy input
// such as the meter push-buttons.
module debounce_filter
   import occupancy_tracker_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          stable_reg;
   logic [CW-1:0] count_reg;

   // A new level is accepted on its DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         count_reg  <= '0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
         if (sync2_reg == stable_reg) begin
            count_reg <= '0;
         end else if (count_reg == COUNT_LAST) begin
            stable_reg <= sync2_reg;
            count_reg  <= '0;
         end else begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign dout = stable_reg;

endmodule

// File: rtl/occupancy_tracker.sv
// Parking-bay occupancy FSM with arrive/depart pulses and saturating dwell timer.
// Build option OCC_GRACE_EN adds a departure grace period of GRACE_SEC seconds.
module occupancy_tracker
   import occupancy_tracker_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int TICK_DIV        = DEF_TICK_DIV,
   parameter int DUR_W           = 16,
   parameter int GRACE_SEC       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             parked_raw,
   output logic             occupied,
   output logic             arrive_pulse,
   output logic             depart_pulse,
   output logic [DUR_W-1:0] dwell_sec,
   output logic [DUR_W-1:0] last_dwell_sec
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] DWELL_MAX = '1;

   logic             stable;
   bay_state_e       state_reg, state_next;
   logic [PW-1:0]    pre_reg;
   logic [DUR_W-1:0] dwell_reg;
   logic [DUR_W-1:0] last_dwell_reg;
   logic             occupied_reg;
   logic             arrive_reg;
   logic             depart_reg;
   logic             arrive_next;
   logic             depart_next;
   logic             tick;

   debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (parked_raw),
      .dout (stable)
   );

   assign tick = (state_reg != VACANT) && (pre_reg == PRE_LAST);

`ifdef OCC_GRACE_EN
   localparam int GW = $clog2(GRACE_SEC + 1);
   localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_SEC - 1);

   logic [GW-1:0] grace_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grace_cnt_reg <= '0;
      end else if ((state_reg != GRACE) && (state_next == GRACE)) begin
         grace_cnt_reg <= '0;
      end else if ((state_reg == GRACE) && tick) begin
         grace_cnt_reg <= grace_cnt_reg + 1'b1;
      end
   end
`else
   if (GRACE_SEC < 1) begin : g_grace_cfg_unused
   end
`endif

   always_comb begin
      state_next  = state_reg;
      arrive_next = 1'b0;
      depart_next = 1'b0;
      case (state_reg)
         VACANT: begin
            if (stable) begin
               state_next  = OCCUPIED;
               arrive_next = 1'b1;
            end
         end
         OCCUPIED: begin
            if (!stable) begin
`ifdef OCC_GRACE_EN
               state_next  = GRACE;
`else
               state_next  = VACANT;
               depart_next = 1'b1;
`endif
            end
         end
`ifdef OCC_GRACE_EN
         GRACE: begin
            // A returning vehicle wins over a grace expiry in the same cycle.
            if (stable) begin
               state_next = OCCUPIED;
            end else if (tick && (grace_cnt_reg == GRACE_LAST)) begin
               state_next  = VACANT;
               depart_next = 1'b1;
            end
         end
`endif
         default: state_next = VACANT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= VACANT;
         pre_reg        <= '0;
         dwell_reg      <= '0;
         last_dwell_reg <= '0;
         occupied_reg   <= 1'b0;
         arrive_reg     <= 1'b0;
         depart_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         occupied_reg <= (state_next != VACANT);
         arrive_reg   <= arrive_next;
         depart_reg   <= depart_next;
         // A tick coinciding with departure is dropped so last_dwell holds the pre-tick value.
         if (arrive_next) begin
            dwell_reg <= '0;
            pre_reg   <= '0;
         end else if (depart_next) begin
            last_dwell_reg <= dwell_reg;
            pre_reg        <= '0;
         end else if (state_reg != VACANT) begin
            if (pre_reg == PRE_LAST) begin
               pre_reg <= '0;
               if (dwell_reg != DWELL_MAX) begin
                  dwell_reg <= dwell_reg + 1'b1;
               end
            end else begin
               pre_reg <= pre_reg + 1'b1;
            end
         end
      end
   end

   assign occupied       = occupied_reg;
   assign arrive_pulse   = arrive_reg;
   assign depart_pulse   = depart_reg;
   assign dwell_sec      = dwell_reg;
   assign last_dwell_sec = last_dwell_reg;

endmodule

// File: tb/tb_occupancy_tracker.sv
// Directed bench for occupancy_tracker (DEBOUNCE_CYCLES=4, TICK_DIV=10, DUR_W=4, GRACE_SEC=2).
// Covers the grace-period behaviour when built with OCC_GRACE_EN.
module tb_occupancy_tracker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       parked_raw;
   logic       occupied;
   logic       arrive_pulse;
   logic       depart_pulse;
   logic [3:0] dwell_sec;
   logic [3:0] last_dwell_sec;

   int checks = 0;
   int errors = 0;

   occupancy_tracker #(
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV       (10),
      .DUR_W          (4),
      .GRACE_SEC      (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .parked_raw    (parked_raw),
      .occupied      (occupied),
      .arrive_pulse  (arrive_pulse),
      .depart_pulse  (depart_pulse),
      .dwell_sec     (dwell_sec),
      .last_dwell_sec(last_dwell_sec)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      logic flag;
      logic seen_arr;
      logic seen_dep;

      rst_n      = 1'b0;
      parked_raw = 1'b0;
      step(3);
      chk("rst_occupied", occupied, 0);
      chk("rst_arrive", arrive_pulse, 0);
      chk("rst_depart", depart_pulse, 0);
      chk("rst_dwell", dwell_sec, 0);
      chk("rst_last", last_dwell_sec, 0);

      // Idle vacant for 50 cycles.
      rst_n = 1'b1;
      flag  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (occupied || arrive_pulse || depart_pulse) flag = 1'b1;
      end
      chk("idle_no_activity", flag, 0);
      chk("idle_dwell", dwell_sec, 0);
      chk("idle_last", last_dwell_sec, 0);

      // 3-cycle glitch must be rejected.
      parked_raw = 1'b1;
      step(3);
      parked_raw = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (occupied || arrive_pulse) flag = 1'b1;
      end
      chk("glitch3_rejected", flag, 0);

      // Clean arrival: pulse on the 7th edge counting the first sampling edge.
      parked_raw = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (arrive_pulse || occupied) flag = 1'b1;
      end
      chk("arrive_not_early", flag, 0);
      step(1);
      chk("arrive_pulse", arrive_pulse, 1);
      chk("arrive_occupied", occupied, 1);
      chk("arrive_dwell0", dwell_sec, 0);
      step(1);
      chk("arrive_one_cycle", arrive_pulse, 0);
      step(8);
      chk("dwell_before_1s", dwell_sec, 0);
      step(1);
      chk("dwell_1s", dwell_sec, 1);
      step(20);
      chk("dwell_3s", dwell_sec, 3);

      // Saturation at 15 over a 250-cycle stay.
      step(150);
      chk("dwell_sat", dwell_sec, 15);
      step(70);
      chk("dwell_no_wrap", dwell_sec, 15);
      chk("stay_occupied", occupied, 1);

      // Reset mid-stay: cleared, no depart pulse, then re-arrival from scratch.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("midrst_occupied", occupied, 0);
      chk("midrst_depart", depart_pulse, 0);
      chk("midrst_dwell", dwell_sec, 0);
      chk("midrst_last", last_dwell_sec, 0);
      flag = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (arrive_pulse || depart_pulse || occupied) flag = 1'b1;
      end
      chk("midrst_quiet", flag, 0);
      step(1);
      chk("rearrive_pulse", arrive_pulse, 1);

`ifdef OCC_GRACE_EN
      // Short drop inside the grace window: no pulses, stays occupied, dwell keeps counting.
      step(3);
      parked_raw = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (!occupied || arrive_pulse || depart_pulse) flag = 1'b1;
      end
      parked_raw = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (!occupied || arrive_pulse || depart_pulse) flag = 1'b1;
      end
      chk("grace_bridge_quiet", flag, 0);
      chk("grace_bridge_dwell", dwell_sec, 3);

      // Held drop: grace entered on a tick edge, departure 20 cycles later.
      step(3);
      parked_raw = 1'b0;
      step(7);
      chk("grace_entry_occupied", occupied, 1);
      chk("grace_entry_dwell", dwell_sec, 4);
      flag = 1'b0;
      for (int i = 0; i < 19; i++) begin
         step(1);
         if (!occupied || depart_pulse) flag = 1'b1;
      end
      chk("grace_hold", flag, 0);
      chk("grace_dwell_counting", dwell_sec, 5);
      step(1);
      chk("grace_depart_pulse", depart_pulse, 1);
      chk("grace_depart_occupied", occupied, 0);
      chk("grace_last_dwell", last_dwell_sec, 5);
      chk("grace_dwell_frozen", dwell_sec, 5);
`else
      // Saturate again, then depart immediately on the debounced drop.
      step(160);
      chk("dwell_sat2", dwell_sec, 15);
      parked_raw = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (depart_pulse || !occupied) flag = 1'b1;
      end
      chk("depart_not_early", flag, 0);
      step(1);
      chk("depart_pulse", depart_pulse, 1);
      chk("depart_occupied", occupied, 0);
      chk("depart_arrive_low", arrive_pulse, 0);
      chk("depart_last", last_dwell_sec, 15);
      chk("depart_dwell", dwell_sec, 15);
      step(1);
      chk("depart_one_cycle", depart_pulse, 0);
      step(20);
      chk("frozen_dwell", dwell_sec, 15);
      chk("frozen_last", last_dwell_sec, 15);

      // A 4-cycle pulse is just long enough to register a (zero-second) stay.
      parked_raw = 1'b1;
      step(4);
      parked_raw = 1'b0;
      seen_arr = 1'b0;
      seen_dep = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (arrive_pulse) seen_arr = 1'b1;
         if (depart_pulse) seen_dep = 1'b1;
      end
      chk("pulse4_arrive", seen_arr, 1);
      chk("pulse4_depart", seen_dep, 1);
      chk("pulse4_occupied", occupied, 0);
      chk("pulse4_last", last_dwell_sec, 0);
      chk("pulse4_dwell", dwell_sec, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
